// File: rtl/score_pkg.sv
// Shared types and helpers for the score sequencer and its BCD incrementer.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        ADD,
        CMP
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Widest score field the comparison helper handles; narrower fields are zero-extended.
    localparam int MAX_DIGITS = 8;
    localparam int BCD_MAX_W  = 4 * MAX_DIGITS;

    // Pending-unit counter width: wide enough that queued goals rarely saturate.
    localparam int PEND_EXTRA_W = 6;

    function automatic int pend_width(input int speed_w);
        return speed_w + PEND_EXTRA_W;
    endfunction

    // Digit-wise BCD greater-than, most significant digit decides first.
    function automatic logic bcd_gt(input logic [BCD_MAX_W-1:0] a,
                                    input logic [BCD_MAX_W-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/score_sequencer_bcd_incr.sv
// Combinational BCD +1 across DIGITS digits with carry-out and all-nines flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever the input is.
module bcd_incr
    import score_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] val,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                all_nines
);

    logic carry;

    // Ripple a +1 from digit 0 upward; a nine rolls to zero and passes the carry on.
    always_comb begin
        sum       = '0;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (val[4*i +: 4] != BCD_NINE) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (val[4*i +: 4] >= BCD_NINE) begin
                    sum[4*i +: 4] = 4'd0;
                end else begin
                    sum[4*i +: 4] = val[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                sum[4*i +: 4] = val[4*i +: 4];
            end
        end
        cout = carry;
    end

endmodule

// File: rtl/score_sequencer.sv
// Game score / best-score controller: goal edges add points serially in BCD, one unit per clock.
// Latency: 1 cycle from input edge to state change; N points take N cycles plus one compare cycle.
// Backpressure: none; goals during addition accumulate in a saturating pending counter (SCORE_WRAP_EN: wrap at all nines).
module score_sequencer
    import score_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int SPEED_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 goal,
    input  logic                 lose,
    input  logic                 hard,
    input  logic [SPEED_W-1:0]   bar_move_speed,
    output logic [4*DIGITS-1:0]  score_bcd,
    output logic [4*DIGITS-1:0]  max_bcd,
    output logic                 busy,
    output logic                 new_record
);

    // DIGITS must not exceed MAX_DIGITS so the shared comparator covers the field.
    localparam int BCD_W  = 4 * DIGITS;
    localparam int PEND_W = pend_width(SPEED_W);
    localparam int PADD_W = PEND_W + 1;
    localparam int PTS_W  = SPEED_W + 1;

    state_t              state, state_nx;
    logic                goal_q, lose_q, start_q;
    logic                goal_rise, lose_rise, start_fall, abort;
    logic [PTS_W-1:0]    pts;
    logic [PEND_W-1:0]   pending, pending_nx;
    logic [PADD_W-1:0]   pend_add;
    logic [BCD_W-1:0]    score_nx, max_nx;
    logic                rec_nx;
    logic [BCD_W-1:0]    inc_sum;
    logic                inc_cout, inc_all_nines, at_top;
    logic [BCD_MAX_W-1:0] score_ext, max_ext;
    logic                score_gt;

    assign goal_rise  = goal & ~goal_q;
    assign lose_rise  = lose & ~lose_q;
    assign start_fall = ~start & start_q;
    // The level check also catches start low when the falling edge fell inside reset.
    assign abort      = start_fall | ~start;

    assign pts      = hard ? {bar_move_speed, 1'b0} : {1'b0, bar_move_speed};
    // One unit is consumed this cycle while the new goal's points join the queue.
    assign pend_add = {1'b0, pending} - PADD_W'(1) + PADD_W'(pts);

    assign busy = (state == ADD);

    bcd_incr #(
        .DIGITS (DIGITS)
    ) u_incr (
        .val       (score_bcd),
        .sum       (inc_sum),
        .cout      (inc_cout),
        .all_nines (inc_all_nines)
    );

    // For a +1 the carry-out and the all-nines flag coincide.
    assign at_top = inc_cout & inc_all_nines;

    // Zero-extend both fields to the comparator width and compare.
    always_comb begin
        score_ext             = '0;
        max_ext               = '0;
        score_ext[BCD_W-1:0]  = score_bcd;
        max_ext[BCD_W-1:0]    = max_bcd;
        score_gt              = bcd_gt(score_ext, max_ext);
    end

    // Input edge detectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            goal_q  <= 1'b0;
            lose_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            goal_q  <= goal;
            lose_q  <= lose;
            start_q <= start;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            score_bcd  <= '0;
            max_bcd    <= '0;
            pending    <= '0;
            new_record <= 1'b0;
        end else begin
            state      <= state_nx;
            score_bcd  <= score_nx;
            max_bcd    <= max_nx;
            pending    <= pending_nx;
            new_record <= rec_nx;
        end
    end

    // Next-state logic: lose beats start-drop beats goal; max only moves in CMP.
    always_comb begin
        state_nx   = state;
        score_nx   = score_bcd;
        max_nx     = max_bcd;
        pending_nx = pending;
        rec_nx     = 1'b0;

        if (state == IDLE) begin
            if (start) begin
                state_nx = PLAY;
            end
        end else if (lose_rise) begin
            score_nx   = '0;
            pending_nx = '0;
            state_nx   = start ? PLAY : IDLE;
        end else if (abort) begin
            score_nx   = '0;
            pending_nx = '0;
            state_nx   = IDLE;
        end else begin
            case (state)
                PLAY: begin
                    if (goal_rise && (pts != '0)) begin
                        pending_nx = PEND_W'(pts);
                        state_nx   = ADD;
                    end
                end
                ADD: begin
`ifdef SCORE_WRAP_EN
                    score_nx = at_top ? '0 : inc_sum;
`else
                    if (!at_top) begin
                        score_nx = inc_sum;
                    end
`endif
                    if (goal_rise) begin
                        pending_nx = pend_add[PEND_W] ? '1 : pend_add[PEND_W-1:0];
                    end else begin
                        pending_nx = pending - PEND_W'(1);
                    end
                    if ((pending == PEND_W'(1)) && !(goal_rise && (pts != '0))) begin
                        state_nx = CMP;
                    end
                end
                CMP: begin
                    if (score_gt) begin
                        max_nx = score_bcd;
                        rec_nx = 1'b1;
                    end
                    state_nx = PLAY;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule
